// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants and helpers for the instruction-fetch front end.
//   INSTR_BYTES : byte distance between consecutive instruction addresses
//   NOP_INSTR   : canonical no-op encoding (addi x0, x0, 0)
//   ptr_inc     : circular pointer increment for a buffer of 'depth' entries
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 32'd4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    // Advance a circular pointer, wrapping to zero after the last entry.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr,
                                            input logic [31:0] depth);
        logic [31:0] nxt_s;
        if (ptr >= (depth - 32'd1)) begin
            nxt_s = 32'd0;
        end else begin
            nxt_s = ptr + 32'd1;
        end
        return nxt_s;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding fetched {pc, instr} pairs in program order.
// Ports:
//   clk, reset       : rising-edge clock, asynchronous active-low reset
//   flush            : empty the buffer next cycle (dominates push and pop)
//   push, push_data  : write an entry
//   pop              : remove the head entry
//   pop_data         : head entry, all zeros while empty
//   count            : number of stored entries
//   empty, full      : occupancy flags
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 41,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic             push_s;
    logic             pop_s;

    // Qualify requests so an empty buffer is never popped and a full one never overwritten.
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        if (pop && (count_r != CNT_ZERO)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (push && ((count_r != CNT_MAX) || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (flush) begin
            wr_ptr_nxt_s = PTR_ZERO;
            rd_ptr_nxt_s = PTR_ZERO;
            count_nxt_s  = CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = PTR_W'(ptr_inc(32'(wr_ptr_r), 32'(DEPTH)));
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = PTR_W'(ptr_inc(32'(rd_ptr_r), 32'(DEPTH)));
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // Entry storage; a write during flush is harmless because the pointers reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign pop_data = (count_r != CNT_ZERO) ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
    assign count    = count_r;
    assign empty    = (count_r == CNT_ZERO);
    assign full     = (count_r == CNT_MAX);

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction-fetch front end: PC generation, instruction-memory handshake and
// an in-order prefetch buffer of {pc, instr} pairs.
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   redirect            : flush everything and restart fetch at redirect_pc
//   redirect_pc         : new fetch address, low two bits ignored
//   imem_req, imem_addr : request to memory, accepted in the cycle asserted
//   imem_rvalid/rdata   : in-order responses, at least one cycle after request
//   out_valid/ready     : head-of-buffer handshake towards decode
//   out_pc, out_instr   : head entry, zero while out_valid is low
//   count, full         : buffer occupancy
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned      PC_W     = 9,
    parameter int unsigned      INS_W    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [PC_W-1:0]  RESET_PC = {PC_W{1'b0}},
    localparam int unsigned     CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_rvalid,
    input  logic [INS_W-1:0] imem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [INS_W-1:0] out_instr,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam int unsigned      CR_W       = CNT_W + 1;
    localparam logic [PC_W-1:0]  PC_STEP    = PC_W'(INSTR_BYTES);
    localparam logic [CR_W-1:0]  CREDIT_MAX = CR_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);

    logic [PC_W-1:0]       fetch_pc_r;
    logic [PC_W-1:0]       resp_pc_r;
    logic [CNT_W-1:0]      inflight_r;
    logic [CNT_W-1:0]      discard_r;
    logic [PC_W-1:0]       fetch_pc_nxt_s;
    logic [PC_W-1:0]       resp_pc_nxt_s;
    logic [CNT_W-1:0]      inflight_nxt_s;
    logic [CNT_W-1:0]      discard_nxt_s;
    logic [PC_W-1:0]       redirect_base_s;
    logic [CNT_W-1:0]      count_s;
    logic [CR_W-1:0]       credit_used_s;
    logic                  issue_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic [PC_W+INS_W-1:0] head_s;
    logic                  unused_redirect_lsb_s;

    assign redirect_base_s       = {redirect_pc[PC_W-1:2], 2'b00};
    assign unused_redirect_lsb_s = ^redirect_pc[1:0];

    // Buffered plus outstanding entries may never exceed DEPTH, so a response
    // always finds a free slot even when nothing is popped that cycle.
    assign credit_used_s = {1'b0, count_s} + {1'b0, inflight_r};
    assign issue_s       = reset && !redirect && (credit_used_s < CREDIT_MAX);
    assign push_s        = imem_rvalid && !redirect && (discard_r == CNT_ZERO);
    assign pop_s         = !fifo_empty_s && out_ready && !redirect;

    // Next PC, outstanding-request and discard counters.
    always_comb begin
        fetch_pc_nxt_s = fetch_pc_r;
        resp_pc_nxt_s  = resp_pc_r;
        inflight_nxt_s = inflight_r;
        discard_nxt_s  = discard_r;
        case ({issue_s, imem_rvalid})
            2'b10:   inflight_nxt_s = inflight_r + CNT_ONE;
            2'b01:   inflight_nxt_s = inflight_r - CNT_ONE;
            default: inflight_nxt_s = inflight_r;
        endcase
        if (redirect) begin
            fetch_pc_nxt_s = redirect_base_s;
            resp_pc_nxt_s  = redirect_base_s;
            // Every response still outstanding after this cycle belongs to the
            // abandoned stream. inflight_r already includes the ones being
            // discarded, so back-to-back redirects do not double-count them.
            if (imem_rvalid) begin
                discard_nxt_s = inflight_r - CNT_ONE;
            end else begin
                discard_nxt_s = inflight_r;
            end
        end else begin
            if (issue_s) begin
                fetch_pc_nxt_s = fetch_pc_r + PC_STEP;
            end else begin
                fetch_pc_nxt_s = fetch_pc_r;
            end
            if (push_s) begin
                resp_pc_nxt_s = resp_pc_r + PC_STEP;
            end else begin
                resp_pc_nxt_s = resp_pc_r;
            end
            if (imem_rvalid && (discard_r != CNT_ZERO)) begin
                discard_nxt_s = discard_r - CNT_ONE;
            end else begin
                discard_nxt_s = discard_r;
            end
        end
    end

    // PC and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            inflight_r <= CNT_ZERO;
            discard_r  <= CNT_ZERO;
        end else begin
            fetch_pc_r <= fetch_pc_nxt_s;
            resp_pc_r  <= resp_pc_nxt_s;
            inflight_r <= inflight_nxt_s;
            discard_r  <= discard_nxt_s;
        end
    end

    fetch_fifo #(
        .WIDTH (PC_W + INS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (push_s),
        .push_data ({resp_pc_r, imem_rdata}),
        .pop       (pop_s),
        .pop_data  (head_s),
        .count     (count_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

    assign imem_req  = issue_s;
    assign imem_addr = fetch_pc_r;
    assign out_valid = !fifo_empty_s;
    assign out_pc    = head_s[PC_W+INS_W-1:INS_W];
    assign out_instr = head_s[INS_W-1:0];
    assign count     = count_s;
    assign full      = fifo_full_s;

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Directed bench for fetch_queue with a behavioural in-order instruction memory
// of programmable latency that returns instr = addr | 0xA000_0000.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int unsigned PC_W  = 9;
    localparam int unsigned INS_W = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PC_W-1:0] RST_PC = 9'h1F8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             redirect = 1'b0;
    logic [PC_W-1:0]  redirect_pc = 9'h000;
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_rvalid;
    logic [INS_W-1:0] imem_rdata;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [PC_W-1:0]  out_pc;
    logic [INS_W-1:0] out_instr;
    logic [CNT_W-1:0] count;
    logic             full;

    int check_cnt = 0;
    int err_cnt   = 0;
    int mem_lat   = 1;
    int cyc       = 0;

    typedef struct packed {
        logic [31:0]     due;
        logic [PC_W-1:0] addr;
    } mem_req_t;

    mem_req_t        pend_q[$];
    logic [PC_W-1:0] req_q[$];

    always #5 clk = ~clk;

    fetch_queue #(
        .PC_W     (PC_W),
        .INS_W    (INS_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .count       (count),
        .full        (full)
    );

    // Instruction memory: accept at mid-cycle, answer in order after mem_lat cycles.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0000_0000;
        forever begin
            @(negedge clk);
            if (reset && imem_req) begin
                pend_q.push_back('{due: 32'(cyc + mem_lat), addr: imem_addr});
            end
            @(posedge clk);
            #1;
            cyc++;
            if (!reset) begin
                pend_q.delete();
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0000_0000;
            end else if ((pend_q.size() > 0) && (pend_q[0].due <= 32'(cyc))) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hA000_0000 | {23'd0, pend_q[0].addr};
                void'(pend_q.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0000_0000;
            end
        end
    end

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int n = 0;
        while (!out_valid && (n < max_cyc)) begin
            tick();
            n++;
        end
        check_value(tag, 64'(out_valid), 64'd1);
    endtask

    task automatic wait_count(input string tag, input logic [CNT_W-1:0] target, input int max_cyc);
        int n = 0;
        while ((count != target) && (n < max_cyc)) begin
            tick();
            n++;
        end
        check_value(tag, 64'(count), 64'(target));
    endtask

    // Hard stop if the bench itself stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [PC_W-1:0] exp_req [4];
        exp_req[0] = 9'h000;
        exp_req[1] = 9'h004;
        exp_req[2] = 9'h008;
        exp_req[3] = 9'h00C;

        // ---- Reset state ----
        repeat (3) tick();
        check_value("rst_out_valid", 64'(out_valid), 64'd0);
        check_value("rst_imem_req",  64'(imem_req),  64'd0);
        check_value("rst_count",     64'(count),     64'd0);
        check_value("rst_full",      64'(full),      64'd0);
        check_value("rst_out_pc",    64'(out_pc),    64'd0);
        check_value("rst_out_instr", 64'(out_instr), 64'd0);

        // ---- Streaming from RESET_PC with PC wrap, 1-cycle memory ----
        reset = 1'b1;
        #1;
        check_value("start_req",  64'(imem_req),  64'd1);
        check_value("start_addr", 64'(imem_addr), 64'h1F8);
        tick();
        check_value("addr_1fc",   64'(imem_addr), 64'h1FC);
        check_value("valid_c1",   64'(out_valid), 64'd0);
        tick();
        check_value("valid_c2",   64'(out_valid), 64'd1);
        check_value("pc0",        64'(out_pc),    64'h1F8);
        check_value("instr0",     64'(out_instr), 64'hA000_01F8);
        check_value("addr_wrap",  64'(imem_addr), 64'h000);
        tick();
        check_value("pc1",        64'(out_pc),    64'h1FC);
        check_value("instr1",     64'(out_instr), 64'hA000_01FC);
        tick();
        check_value("pc_wrap",    64'(out_pc),    64'h000);
        check_value("instr_wrap", 64'(out_instr), 64'hA000_0000);
        tick();
        check_value("pc3",        64'(out_pc),    64'h004);

        // ---- Fill with consumer stalled, then drain ----
        redirect    = 1'b1;
        redirect_pc = 9'h000;
        out_ready   = 1'b0;
        #1;
        check_value("redir_noreq", 64'(imem_req), 64'd0);
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (imem_req) req_q.push_back(imem_addr);
            tick();
        end
        check_value("fill_nreq", 64'(req_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check_value("fill_addr", 64'((i < req_q.size()) ? req_q[i] : 9'h1FF), 64'(exp_req[i]));
        end
        check_value("fill_count", 64'(count),     64'd4);
        check_value("fill_full",  64'(full),      64'd1);
        check_value("fill_noreq", 64'(imem_req),  64'd0);
        check_value("fill_head",  64'(out_pc),    64'h000);
        out_ready = 1'b1;
        tick();
        check_value("drain_pc4",   64'(out_pc),    64'h004);
        check_value("resume_req",  64'(imem_req),  64'd1);
        check_value("resume_addr", 64'(imem_addr), 64'h010);
        tick();
        check_value("drain_pc8",   64'(out_pc),    64'h008);
        tick();
        check_value("drain_pcc",   64'(out_pc),    64'h00C);
        tick();
        check_value("drain_pc10",  64'(out_pc),    64'h010);
        check_value("drain_ins10", 64'(out_instr), 64'hA000_0010);

        // ---- 3-cycle memory: redirect with two requests in flight ----
        mem_lat     = 3;
        redirect    = 1'b1;
        redirect_pc = 9'h100;
        out_ready   = 1'b0;
        tick();
        redirect = 1'b0;
        #1;
        check_value("lat3_addr", 64'(imem_addr), 64'h100);
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 9'h043;
        tick();
        redirect = 1'b0;
        #1;
        check_value("align_addr", 64'(imem_addr), 64'h040);
        check_value("drop_cnt0",  64'(count),     64'd0);
        tick();
        tick();
        check_value("drop_cnt2",  64'(count),     64'd0);
        tick();
        check_value("drop_cnt3",  64'(count),     64'd0);
        tick();
        check_value("tgt_valid",  64'(out_valid), 64'd1);
        check_value("tgt_pc",     64'(out_pc),    64'h040);
        check_value("tgt_instr",  64'(out_instr), 64'hA000_0040);
        check_value("tgt_count",  64'(count),     64'd1);

        // ---- Redirect together with response and pop, count=2 ----
        tick();
        check_value("pre_count2", 64'(count), 64'd2);
        redirect    = 1'b1;
        redirect_pc = 9'h080;
        out_ready   = 1'b1;
        tick();
        redirect = 1'b0;
        check_value("flush_count", 64'(count),     64'd0);
        check_value("flush_valid", 64'(out_valid), 64'd0);
        wait_valid("flush_wait", 20);
        check_value("flush_pc",    64'(out_pc),    64'h080);
        check_value("flush_instr", 64'(out_instr), 64'hA000_0080);
        tick();
        check_value("flush_pc2",   64'(out_pc),    64'h084);

        // ---- Back-to-back redirects ----
        redirect    = 1'b1;
        redirect_pc = 9'h0C0;
        tick();
        redirect_pc = 9'h100;
        tick();
        redirect = 1'b0;
        check_value("b2b_count", 64'(count), 64'd0);
        wait_valid("b2b_wait", 20);
        check_value("b2b_pc0",   64'(out_pc), 64'h100);
        tick();
        check_value("b2b_pc1",   64'(out_pc), 64'h104);
        tick();
        check_value("b2b_pc2",   64'(out_pc), 64'h108);

        // ---- Asynchronous reset with a partly full buffer ----
        out_ready = 1'b0;
        wait_count("pre_rst_count", 3'd3, 30);
        reset = 1'b0;
        #1;
        check_value("arst_valid", 64'(out_valid), 64'd0);
        check_value("arst_req",   64'(imem_req),  64'd0);
        check_value("arst_count", 64'(count),     64'd0);
        check_value("arst_full",  64'(full),      64'd0);
        tick();
        tick();
        mem_lat   = 1;
        out_ready = 1'b1;
        reset     = 1'b1;
        #1;
        check_value("rel_req",  64'(imem_req),  64'd1);
        check_value("rel_addr", 64'(imem_addr), 64'h1F8);
        tick();
        tick();
        check_value("rel_pc",   64'(out_pc),    64'h1F8);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
